// File: rtl/proc_multiciclo_param.sv
`default_nettype none
// =============================================================================
// proc_multiciclo_param : parametrised multicycle core, 8 regs (R7 = PC),
// single internal bus, external imem/dmem behind req/ready handshakes.
// Optional macro PROC_INSTR_COUNT_EN adds the 32-bit instr_count output.
// Revision: 1.0
// =============================================================================
module proc_multiciclo_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 6,
   parameter int RESET_PC = 0
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires,
   output logic [DATA_W-1:0] Rx_data,
   output logic [DATA_W-1:0] Ry_data,
   output logic [2:0]        Tstep
`ifdef PROC_INSTR_COUNT_EN
   ,
   output logic [31:0]       instr_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_IMM    = 3'd3,
      S_ALU    = 3'd4,
      S_WB     = 3'd5,
      S_MEM    = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVNZ = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;

   localparam logic [DATA_W-1:0] RESET_PC_W = DATA_W'(RESET_PC);
   localparam logic [DATA_W-1:0] ONE_W      = DATA_W'(1);

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] regs [0:7];
   logic [DATA_W-1:0] acc_a;
   logic [DATA_W-1:0] res_g;
   logic [DATA_W-1:0] alu_result;
   logic [9:0]        ir;
   logic [3:0]        opcode;
   logic [2:0]        rx;
   logic [2:0]        ry;

   assign opcode    = ir[9:6];
   assign rx        = ir[5:3];
   assign ry        = ir[2:0];
   assign Rx_data   = regs[rx];
   assign Ry_data   = regs[ry];
   assign imem_addr = regs[7][ADDR_W-1:0];
   assign Tstep     = state;

   // Every register write is sourced from the bus, so the bus contents follow the state.
   always_comb begin
      BusWires = '0;
      case (state)
         S_FETCH, S_IMM:  BusWires = imem_rdata;
         S_DECODE, S_ALU: BusWires = Ry_data;
         S_WB:            BusWires = res_g;
         S_MEM:           BusWires = dmem_rdata;
         default:         BusWires = '0;
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (opcode)
         OP_ADD:  alu_result = acc_a + BusWires;
         OP_SUB:  alu_result = acc_a - BusWires;
         OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, (acc_a < BusWires)};
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = Run ? S_FETCH : S_IDLE;
         S_FETCH:  next_state = imem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_MVI:                 next_state = S_IMM;
               OP_LD, OP_ST:           next_state = S_MEM;
               OP_ADD, OP_SUB, OP_SLT: next_state = S_ALU;
               default:                next_state = S_DONE;
            endcase
         end
         S_IMM:    next_state = imem_ready ? S_DONE : S_IMM;
         S_ALU:    next_state = S_WB;
         S_WB:     next_state = S_DONE;
         S_MEM:    next_state = dmem_ready ? S_DONE : S_MEM;
         S_DONE:   next_state = Run ? S_FETCH : S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so they are clean
   // from the first cycle of each state and drop at once on reset.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= S_IDLE;
         ir         <= '0;
         acc_a      <= '0;
         res_g      <= '0;
         for (int i = 0; i < 7; i++) regs[i] <= '0;
         regs[7]    <= RESET_PC_W;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         Done       <= 1'b0;
      end else begin
         state    <= next_state;
         imem_req <= (next_state == S_FETCH) || (next_state == S_IMM);
         dmem_req <= (next_state == S_MEM);
         Done     <= (next_state == S_DONE);
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  ir      <= imem_rdata[9:0];
                  regs[7] <= regs[7] + ONE_W;
               end
            end
            S_DECODE: begin
               acc_a <= Rx_data;
               if ((opcode == OP_MV) || ((opcode == OP_MVNZ) && (res_g != '0)))
                  regs[rx] <= BusWires;
               if (next_state == S_MEM) begin
                  dmem_we    <= (opcode == OP_ST);
                  dmem_addr  <= Ry_data[ADDR_W-1:0];
                  dmem_wdata <= Rx_data;
               end
            end
            S_IMM: begin
               // A write to R7 is ordered after the increment so it wins (jump).
               if (imem_ready) begin
                  regs[7]  <= regs[7] + ONE_W;
                  regs[rx] <= BusWires;
               end
            end
            S_ALU:   res_g    <= alu_result;
            S_WB:    regs[rx] <= BusWires;
            S_MEM: begin
               if (dmem_ready) begin
                  if (opcode == OP_LD) regs[rx] <= BusWires;
                  dmem_we <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PROC_INSTR_COUNT_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         instr_count <= '0;
      else if (Done)
         instr_count <= instr_count + 32'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_multiciclo_param.sv
`default_nettype none
// =============================================================================
// tb_proc_multiciclo_param : self-checking bench with wait-state memory models
// and a data-access scoreboard. Revision: 1.0
// =============================================================================
module tb_proc_multiciclo_param;

   localparam int DW  = 16;
   localparam int AW  = 6;
   localparam int RPC = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          Run = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata = '0;
   logic          imem_ready = 1'b0;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata = '0;
   logic          dmem_ready = 1'b0;
   logic          Done;
   logic [DW-1:0] BusWires;
   logic [DW-1:0] Rx_data;
   logic [DW-1:0] Ry_data;
   logic [2:0]    Tstep;
`ifdef PROC_INSTR_COUNT_EN
   logic [31:0]   instr_count;
`endif

   logic [DW-1:0] imem [0:63];
   logic [DW-1:0] dmem [0:63];
   acc_t          exp_q[$];
   acc_t          cur;
   int            n_tests = 0;
   int            n_fail = 0;
   int            done_cnt = 0;
   int            iwait = 0;
   int            dwait = 0;
   int            icnt = 0;
   int            dcnt = 0;
   int            wp = RPC;
   logic          prev_done = 1'b0;
   logic          done_due = 1'b0;

   proc_multiciclo_param #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
`ifdef PROC_INSTR_COUNT_EN
      .instr_count (instr_count),
`endif
      .Clock       (Clock),
      .Resetn      (Resetn),
      .Run         (Run),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ready  (dmem_ready),
      .Done        (Done),
      .BusWires    (BusWires),
      .Rx_data     (Rx_data),
      .Ry_data     (Ry_data),
      .Tstep       (Tstep)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory responders and retire monitor, all on the falling edge.
   always @(negedge Clock) begin
      if (done_due) begin
         check("done_after_dmem_ready", {31'd0, Done}, 32'd1);
         done_due = 1'b0;
      end
      if (Done) begin
         check("done_single_cycle", {31'd0, prev_done}, 32'd0);
         done_cnt++;
      end
      prev_done = Done;

      if (imem_req) begin
         imem_rdata = imem[imem_addr];
         if (icnt >= iwait) begin
            imem_ready = 1'b1;
            icnt = 0;
         end else begin
            imem_ready = 1'b0;
            icnt++;
         end
      end else begin
         imem_ready = 1'b0;
         icnt = 0;
      end

      if (dmem_req) begin
         if (dcnt == 0) begin
            if (exp_q.size() == 0) begin
               check("dmem_unexpected_access", 32'd1, 32'd0);
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
            end
         end
         check("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
         check("dmem_addr", {26'd0, dmem_addr}, {26'd0, cur.addr});
         if (cur.we) check("dmem_wdata", {16'd0, dmem_wdata}, {16'd0, cur.data});
         check("req_exclusive", {31'd0, imem_req}, 32'd0);
         dmem_rdata = dmem[dmem_addr];
         if (dcnt >= dwait) begin
            dmem_ready = 1'b1;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            done_due = 1'b1;
            dcnt = 0;
         end else begin
            dmem_ready = 1'b0;
            dcnt++;
         end
      end else begin
         dmem_ready = 1'b0;
         dcnt = 0;
      end
   end

   function automatic logic [DW-1:0] enc(input logic [3:0] op, input int rx, input int ry);
      return {6'b101010, op, 3'(rx), 3'(ry)};
   endfunction

   task automatic put(input logic [DW-1:0] w);
      imem[wp] = w;
      wp++;
   endtask

   task automatic mvi(input int rx, input logic [DW-1:0] imm);
      put(enc(4'b0001, rx, 0));
      put(imm);
   endtask

   task automatic push_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      acc_t e;
      e.we = we; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic run_n(input int n, input string tag);
      int start;
      int cyc;
      start = done_cnt;
      cyc = 0;
      Run = 1'b1;
      while (((done_cnt - start) < n) && (cyc < 600)) begin
         @(negedge Clock);
         #1;
         cyc++;
      end
      Run = 1'b0;
      repeat (3) @(negedge Clock);
      #1;
      check({tag, "_retired"}, done_cnt - start, n);
      check({tag, "_idle"}, {29'd0, Tstep}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int saved;
      int cyc;
      for (int i = 0; i < 64; i++) begin
         imem[i] = '0;
         dmem[i] = '0;
      end
      // Program, laid out from RESET_PC; data accesses pushed in execution order.
      mvi(0, 16'd5); mvi(1, 16'd3); put(enc(4'b0011, 0, 1));            // 4..8
      mvi(0, 16'hFFFF); mvi(1, 16'd1); put(enc(4'b0010, 0, 1));         // 9..13
      mvi(2, 16'd7); put(enc(4'b0110, 2, 1));                           // 14..16
      put(enc(4'b0011, 1, 0)); put(enc(4'b0110, 2, 1));                 // 17..18
      mvi(3, 16'd5); mvi(4, 16'd9);                                     // 19..22
      put(enc(4'b0111, 3, 4)); put(enc(4'b0111, 4, 3));                 // 23..24
      put(enc(4'b0000, 6, 2)); put(enc(4'b1010, 6, 0));                 // 25..26
      mvi(0, 16'h1234); mvi(1, 16'd10);                                 // 27..30
      put(enc(4'b0101, 0, 1)); push_acc(1'b1, 6'd10, 16'h1234);         // 31
      put(enc(4'b0100, 6, 1)); push_acc(1'b0, 6'd10, 16'h0000);         // 32
      mvi(7, 16'd40);                                                   // 33..34
      wp = 40;
      mvi(2, 16'd50);
      put(enc(4'b0101, 2, 2)); push_acc(1'b1, 6'd50, 16'd50);           // 42
      mvi(3, 16'd60);
      put(enc(4'b0101, 2, 3)); push_acc(1'b1, 6'd60, 16'd50);           // 45

      repeat (3) @(negedge Clock);
      #1;
      check("rst_tstep", {29'd0, Tstep}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_pc", {26'd0, imem_addr}, RPC);
      check("rst_bus", {16'd0, BusWires}, 32'd0);
`ifdef PROC_INSTR_COUNT_EN
      check("rst_instr_count", instr_count, 32'd0);
`endif
      Resetn = 1'b1;

      run_n(3, "sub");
      check("sub_pc", {26'd0, imem_addr}, RPC + 5);
      check("sub_r0", {16'd0, Rx_data}, 32'd2);
      check("sub_r1", {16'd0, Ry_data}, 32'd3);

      run_n(3, "add_wrap");
      check("add_wrap_r0", {16'd0, Rx_data}, 32'd0);
      check("add_wrap_r1", {16'd0, Ry_data}, 32'd1);

      run_n(2, "mvnz_g0");
      check("mvnz_g0_r2", {16'd0, Rx_data}, 32'd7);

      run_n(2, "mvnz_g1");
      check("mvnz_g1_r2", {16'd0, Rx_data}, 32'd1);

      run_n(4, "slt");
      check("slt_false_r4", {16'd0, Rx_data}, 32'd0);
      check("slt_true_r3", {16'd0, Ry_data}, 32'd1);

      run_n(2, "mv_nop");
      check("mv_nop_r6", {16'd0, Rx_data}, 32'd1);
      check("mv_nop_r0", {16'd0, Ry_data}, 32'd0);

      dwait = 3;
      iwait = 1;
      run_n(4, "st_ld_wait");
      check("ld_r6", {16'd0, Rx_data}, 32'h1234);
      check("ld_r1", {16'd0, Ry_data}, 32'd10);
      iwait = 0;

      run_n(1, "jump");
      check("jump_pc", {26'd0, imem_addr}, 32'd40);

      dwait = 0;
      run_n(2, "st_after_jump");

      // Reset in the middle of a long data access.
      dwait = 100;
      Run = 1'b1;
      cyc = 0;
      while (!dmem_req && (cyc < 100)) begin
         @(negedge Clock);
         #1;
         cyc++;
      end
      check("abort_req_seen", {31'd0, dmem_req}, 32'd1);
      repeat (2) @(negedge Clock);
      saved = done_cnt;
      #2 Resetn = 1'b0;
      #1;
      check("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("abort_tstep", {29'd0, Tstep}, 32'd0);
      check("abort_pc", {26'd0, imem_addr}, RPC);
      Run = 1'b0;
      repeat (3) @(negedge Clock);
      check("abort_no_retire", done_cnt - saved, 32'd0);
      check("sb_empty", exp_q.size(), 32'd0);
      dwait = 0;
      #1 Resetn = 1'b1;

      run_n(3, "recover");
      check("recover_pc", {26'd0, imem_addr}, RPC + 5);
      check("recover_r0", {16'd0, Rx_data}, 32'd2);
`ifdef PROC_INSTR_COUNT_EN
      check("count_after_3", instr_count, 32'd3);
`endif
      run_n(3, "recover2");
      check("recover2_r0", {16'd0, Rx_data}, 32'd0);
`ifdef PROC_INSTR_COUNT_EN
      check("count_after_6", instr_count, 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
